// File: rtl/load_store_unit_if.sv
// Single-ported data-memory request/acknowledge bus between the load/store unit (master)
// and data memory (slave).
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: formats stores, aligns/extends loads, and stalls
// the pipeline until the data-memory access completes, faults or times out.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic [2:0]                i_funct3,
    input  logic [31:0]               i_addr,
    input  logic [31:0]               i_store_data,
    load_store_unit_if.master         dmem,
    output logic                      o_stall,
    output logic [31:0]               o_load_data,
    output logic [1:0]                o_fault
);

    localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic        r_req, w_req_d;
    logic        r_we, w_we_d;
    logic [3:0]  r_be, w_be_d;
    logic [31:0] r_addr, w_addr_d;
    logic [31:0] r_wdata, w_wdata_d;
    logic [2:0]  r_funct3, w_funct3_d;
    logic [1:0]  r_off, w_off_d;
    logic [31:0] r_load_data, w_load_data_d;
    logic [1:0]  r_fault, w_fault_d;

    logic        w_start;
    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_fmt_be;
    logic [31:0] w_fmt_wdata;
    logic [31:0] w_shifted;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_start = i_valid & (i_mem_read | i_mem_write);

    assign w_illegal = (i_mem_read & i_mem_write)
                     | (i_mem_read & ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11)))
                     | (i_mem_write & i_funct3[2]);

    assign w_misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0])
                        | ((i_funct3[1:0] == 2'b10) & (|i_addr[1:0]));

    always_comb begin
        w_fmt_be    = 4'b1111;
        w_fmt_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                w_fmt_be    = 4'b0001 << i_addr[1:0];
                w_fmt_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                w_fmt_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_fmt_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the latched size/offset, not the live EX/MEM inputs.
    assign w_shifted = dmem.rdata >> {r_off, 3'b000};
    assign w_half    = r_off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    always_comb begin
        w_ext = dmem.rdata;
        case (r_funct3[1:0])
            2'b00:   w_ext = {{24{~r_funct3[2] & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_ext = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_req_d       = r_req;
        w_we_d        = r_we;
        w_be_d        = r_be;
        w_addr_d      = r_addr;
        w_wdata_d     = r_wdata;
        w_funct3_d    = r_funct3;
        w_off_d       = r_off;
        w_load_data_d = r_load_data;
        w_fault_d     = r_fault;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    if (w_illegal) begin
                        w_fault_d     = 2'b11;
                        w_load_data_d = '0;
                        w_state_d     = StDone;
                    end else if (w_misaligned) begin
                        w_fault_d     = 2'b01;
                        w_load_data_d = '0;
                        w_state_d     = StDone;
                    end else begin
                        w_addr_d   = {i_addr[31:2], 2'b00};
                        w_we_d     = i_mem_write;
                        w_be_d     = i_mem_write ? w_fmt_be : 4'b0000;
                        w_wdata_d  = w_fmt_wdata;
                        w_funct3_d = i_funct3;
                        w_off_d    = i_addr[1:0];
                        w_req_d    = 1'b1;
                        w_cnt_d    = '0;
                        w_state_d  = StBusy;
                    end
                end
            end
            StBusy: begin
                if (dmem.ack) begin
                    w_req_d   = 1'b0;
                    w_fault_d = 2'b00;
                    if (!r_we) w_load_data_d = w_ext;
                    w_state_d = StDone;
                end else if (r_cnt == CntMax) begin
                    w_req_d       = 1'b0;
                    w_fault_d     = 2'b10;
                    w_load_data_d = '0;
                    w_state_d     = StDone;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= 4'b0000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_load_data <= '0;
            r_fault     <= 2'b00;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_req       <= w_req_d;
            r_we        <= w_we_d;
            r_be        <= w_be_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_funct3    <= w_funct3_d;
            r_off       <= w_off_d;
            r_load_data <= w_load_data_d;
            r_fault     <= w_fault_d;
        end
    end

    assign o_stall     = ((r_state == StIdle) & w_start) | (r_state == StBusy);
    assign o_load_data = r_load_data;
    assign o_fault     = r_fault;
    assign dmem.req    = r_req;
    assign dmem.we     = r_we;
    assign dmem.be     = r_be;
    assign dmem.addr   = r_addr;
    assign dmem.wdata  = r_wdata;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV32I core. It takes a decoded load or store from the execute stage and drives a single-ported data-memory request/acknowledge bus. It generates byte enables and the replicated store data, then aligns and sign- or zero-extends returned load data. The registered `load_data` result feeds the memory-data input (select `2'b01`) of the writeback 4-to-1 mux, and `stall` holds the pipeline until the access completes.

## Interface
- `TIMEOUT`, default 255: maximum BUSY cycles without `dmem_ack` before the access is aborted. Legal range is 1–255, held in an 8-bit counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `valid` in 1: an EX/MEM instruction is present; sampled only in IDLE.
- `mem_read` in 1: the instruction is a load.
- `mem_write` in 1: the instruction is a store.
- `funct3` in 3: access size and sign. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- `addr` in 32: effective byte address.
- `store_data` in 32: rs2 value.
- `dmem_rdata` in 32: memory read word.
- `dmem_ack` in 1: memory completion, one cycle.
- `stall` out 1: holds the upstream pipeline (combinational).
- `load_data` out 32: extended load result (registered).
- `fault` out 2: 00 none, 01 misaligned, 10 bus timeout, 11 illegal op (registered).
- `dmem_req` out 1: request strobe (registered).
- `dmem_we` out 1: 1 means write.
- `dmem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: replicated store data.
- `dmem_be` out 4: byte enables; always 0000 for reads.

## Operation
- `start` = `valid & (mem_read | mem_write)` in IDLE.
- FSM states are IDLE, BUSY and DONE.
- IDLE, no `start`: remain in IDLE.
- IDLE, `start`, legal aligned access:
  - latch `dmem_addr`, `dmem_we`, `dmem_be`, `dmem_wdata`, `funct3` and `addr[1:0]`;
  - set `dmem_req`=1;
  - clear the wait counter;
  - go to BUSY.
- IDLE, `start`, misaligned access (LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0):
  - no request is issued;
  - `fault`←01, `load_data`←0;
  - go to DONE.
- IDLE, `start`, illegal access (`mem_read&mem_write`, a load with `funct3`∈{011,110,111}, or a store with `funct3`[2]=1):
  - `fault`←11, `load_data`←0;
  - go to DONE.
- BUSY, `dmem_ack`=1:
  - `dmem_req`←0;
  - for a read, `load_data`←extended data; for a write, `load_data` is unchanged;
  - `fault`←00;
  - go to DONE.
- BUSY, no ack, counter = `TIMEOUT`-1:
  - `dmem_req`←0, `fault`←10, `load_data`←0;
  - go to DONE.
- BUSY otherwise: increment the counter; request fields stay stable.
- DONE: always go to IDLE. `valid` is ignored in DONE.
- Store formatting:
  - SB: `be`=0001<<`addr[1:0]`, `wdata`={4{`store_data[7:0]`}}.
  - SH: `be`=`addr[1]`?1100:0011, `wdata`={2{`store_data[15:0]`}}.
  - SW: `be`=1111, `wdata`=`store_data`.
- Load extraction:
  - byte = `dmem_rdata[8*a+7:8*a]` with a=`addr[1:0]`;
  - half = `addr[1]` ? `[31:16]` : `[15:0]`;
  - sign-extend when `funct3[2]`=0, zero-extend when 1; LW passes the word through.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `dmem_req`=0, `dmem_we`=0, `dmem_be`=0000;
  - `dmem_addr`=0, `dmem_wdata`=0;
  - `load_data`=0, `fault`=00, `stall`=0.
- `stall` = (IDLE & `start`) | BUSY. It is 0 in DONE, which lets the pipeline advance for exactly one edge.
- Aligned access with the ack in the first BUSY cycle gives 2 stall cycles, then DONE. Each extra wait cycle adds one stall cycle.
- `load_data` and `fault` are valid in DONE and hold until the next access completes.
- Faulting accesses: 1 stall cycle, then DONE.
- Timeout: the request is deasserted after exactly `TIMEOUT` BUSY cycles.
- `dmem_ack` outside BUSY is ignored.
- `rst` asserted in any state (including BUSY): the next edge forces reset values, with no DONE and no `load_data` update.

## Test plan
- LB at `addr`=0x103 with `dmem_rdata`=0x80FF_1234, ack after 2 waits -> `dmem_be`=0000, `dmem_addr`=0x100, 4 stall cycles, `load_data`=0xFFFF_FF80, `fault`=00.
- LHU at 0x202 with `rdata`=0xBEEF_0000, immediate ack -> `load_data`=0x0000_BEEF, 2 stall cycles.
- SB at 0x301 with `store_data`=0xAABB_CC5A -> `dmem_we`=1, `be`=0010, `wdata`=0x5A5A_5A5A. SW at 0x300 -> `be`=1111.
- LW at 0x402 -> no `dmem_req` ever, `fault`=01, `load_data`=0, 1 stall cycle.
- `TIMEOUT`=4, no ack -> `dmem_req` high for exactly 4 cycles, then `fault`=10.
- `rst` pulsed during BUSY -> `dmem_req`=0 on the next edge, `stall`=0. A late `dmem_ack` is ignored.
